mac_execute_sequencer: RTL and testbench

Consumer side of the MAC instruction register. Reads the 26-bit MIR value (bit 25 = valid, bits 24:0 = MAC instruction) and runs a multi-cycle multiply-accumulate loop over register-file operands. Writes the result to rd. Drives MIR_updated back into the MIR every cycle, so the MIR always holds the live loop state and is retired by clearing its valid bit. Sits beside the execute stage and stalls the front end through mac_busy.

---
 rtl/mac_execute_sequencer.sv | 137 +++++++++++++
 tb/tb_mac_execute_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_execute_sequencer.sv
// MAC execute sequencer: consumes the MIR and runs a FETCH/MULT loop, writing acc to rd.
// Optional writeback clamping is built when MAC_SATURATE_EN is defined.
module mac_execute_sequencer #(
   parameter int XLEN = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [25:0]       mac_IR_reg,
   output logic [25:0]       MIR_updated,
   output logic [4:0]        rf_rd_addr1,
   output logic [4:0]        rf_rd_addr2,
   input  logic [XLEN-1:0]   rf_rd_data1,
   input  logic [XLEN-1:0]   rf_rd_data2,
   output logic              rf_wr_en,
   output logic [4:0]        rf_wr_addr,
   output logic [XLEN-1:0]   rf_wr_data,
   output logic              mac_busy,
   output logic              mac_done
);

   // state | meaning
   // IDLE  | waiting for MIR valid; optional acc clear on launch
   // FETCH | read rs1/rs2 from the register file into op_a/op_b
   // MULT  | acc += op_a*op_b; MIR advances count/rs1/rs2
   // WRITE | write acc (or clamp) to rd, pulse done, retire MIR
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MULT, S_WRITE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [2*XLEN-1:0]     r_acc;
   logic [XLEN-1:0]       r_op_a;
   logic [XLEN-1:0]       r_op_b;

   logic                  w_valid;
   logic [4:0]            w_rd;
   logic [4:0]            w_rs1;
   logic [4:0]            w_rs2;
   logic [7:0]            w_count;
   logic                  w_sgn;
   logic                  w_clr;
   logic [2*XLEN-1:0]     w_ext_a;
   logic [2*XLEN-1:0]     w_ext_b;
   logic [2*XLEN-1:0]     w_prod;
   logic [XLEN-1:0]       w_wb_data;

   assign w_valid = mac_IR_reg[25];
   assign w_rd    = mac_IR_reg[24:20];
   assign w_rs1   = mac_IR_reg[19:15];
   assign w_rs2   = mac_IR_reg[14:10];
   assign w_count = mac_IR_reg[9:2];
   assign w_sgn   = mac_IR_reg[1];
   assign w_clr   = mac_IR_reg[0];

   assign w_ext_a = w_sgn ? {{XLEN{r_op_a[XLEN-1]}}, r_op_a} : {{XLEN{1'b0}}, r_op_a};
   assign w_ext_b = w_sgn ? {{XLEN{r_op_b[XLEN-1]}}, r_op_b} : {{XLEN{1'b0}}, r_op_b};
   assign w_prod  = w_ext_a * w_ext_b;

`ifdef MAC_SATURATE_EN
   logic w_fits_signed;
   logic w_fits_unsigned;

   // Signed fit: every bit above the XLEN sign bit must match it.
   assign w_fits_signed   = (&r_acc[2*XLEN-1:XLEN-1]) | ~(|r_acc[2*XLEN-1:XLEN-1]);
   assign w_fits_unsigned = ~(|r_acc[2*XLEN-1:XLEN]);

   always_comb begin
      w_wb_data = r_acc[XLEN-1:0];
      if (w_sgn) begin
         if (!w_fits_signed)
            w_wb_data = r_acc[2*XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
      end else if (!w_fits_unsigned) begin
         w_wb_data = '1;
      end
   end
`else
   assign w_wb_data = r_acc[XLEN-1:0];
`endif

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_acc  <= '0;
         r_op_a <= '0;
         r_op_b <= '0;
      end else begin
         if (r_state == S_IDLE && w_valid && w_clr) r_acc <= '0;
         if (r_state == S_FETCH) begin
            r_op_a <= rf_rd_data1;
            r_op_b <= rf_rd_data2;
         end
         if (r_state == S_MULT) r_acc <= r_acc + w_prod;
      end
   end

   always_comb begin
      w_next      = r_state;
      MIR_updated = mac_IR_reg;
      rf_rd_addr1 = '0;
      rf_rd_addr2 = '0;
      rf_wr_en    = 1'b0;
      rf_wr_addr  = '0;
      rf_wr_data  = '0;
      mac_busy    = 1'b1;
      mac_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            mac_busy = 1'b0;
            if (w_valid) w_next = S_FETCH;
         end
         S_FETCH: begin
            rf_rd_addr1 = w_rs1;
            rf_rd_addr2 = w_rs2;
            w_next      = S_MULT;
         end
         S_MULT: begin
            // count==0 falls through to WRITE just like count==1
            MIR_updated = {w_valid, w_rd, w_rs1 + 5'd1, w_rs2 + 5'd1,
                           w_count - 8'd1, w_sgn, w_clr};
            w_next      = (w_count <= 8'd1) ? S_WRITE : S_FETCH;
         end
         S_WRITE: begin
            MIR_updated = {1'b0, mac_IR_reg[24:0]};
            rf_wr_en    = (w_rd != 5'd0);
            rf_wr_addr  = w_rd;
            rf_wr_data  = w_wb_data;
            mac_done    = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mac_execute_sequencer.sv
// Bench for mac_execute_sequencer: directed scenarios plus random instructions against
// a dot-product reference model; honours MAC_SATURATE_EN for the expected writeback.
module tb_mac_execute_sequencer;
   localparam int XLEN = 32;
   localparam longint SMAX = 64'sh000000007FFFFFFF;
   localparam longint SMIN = -64'sh0000000080000000;

   logic              clock = 1'b0;
   logic              reset;
   logic [25:0]       mac_IR_reg;
   logic [25:0]       MIR_updated;
   logic [4:0]        rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
   logic [XLEN-1:0]   rf_rd_data1, rf_rd_data2, rf_wr_data;
   logic              rf_wr_en, mac_busy, mac_done;

   logic [XLEN-1:0]   rf [32];
   logic              load_q;
   logic [25:0]       load_val;
   logic [63:0]       m_acc;
   int                n_cmp = 0;
   int                n_err = 0;

   mac_execute_sequencer #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .mac_IR_reg(mac_IR_reg), .MIR_updated(MIR_updated),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .mac_busy(mac_busy), .mac_done(mac_done)
   );

   always #5 clock = ~clock;

   assign rf_rd_data1 = rf[rf_rd_addr1];
   assign rf_rd_data2 = rf[rf_rd_addr2];

   // MIR model: loads a new instruction when asked, otherwise follows MIR_updated.
   always @(posedge clock) begin
      if (load_q && load_val[25])
         assert (!mac_busy) else $error("FAIL protocol: is_mac while busy observed=%b expected=0", mac_busy);
      mac_IR_reg <= load_q ? load_val : MIR_updated;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [25:0] mk(input int rd, input int rs1, input int rs2,
                                      input int cnt, input bit sgn, input bit clr);
      return {1'b1, 5'(rd), 5'(rs1), 5'(rs2), 8'(cnt), sgn, clr};
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 4))
         0:       return 32'h7FFFFFFF;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic scramble_rf();
      for (int r = 0; r < 32; r++) rf[r] = rnd_val();
   endtask

   task automatic issue(input logic [25:0] instr);
      @(negedge clock);
      load_val = instr;
      load_q   = 1'b1;
      @(posedge clock);
      #1 load_q = 1'b0;
   endtask

   // Called during cycle 0 (the cycle IDLE sees valid). abort_k>0 applies reset in that cycle.
   task automatic follow(input logic [25:0] instr, input int abort_k);
      int          rd, rs1, rs2, cnt, n, ai, bi, i;
      bit          sgn, clr;
      logic [63:0] acc, prod;
      longint      sacc;
      logic [31:0] wb;
      logic [25:0] emir;
      rd  = int'(instr[24:20]);
      rs1 = int'(instr[19:15]);
      rs2 = int'(instr[14:10]);
      cnt = int'(instr[9:2]);
      sgn = instr[1];
      clr = instr[0];
      n   = (cnt == 0) ? 1 : cnt;
      acc = clr ? 64'd0 : m_acc;
      for (int s = 0; s < n; s++) begin
         ai = (rs1 + s) % 32;
         bi = (rs2 + s) % 32;
         if (sgn) prod = longint'($signed(rf[ai])) * longint'($signed(rf[bi]));
         else     prod = 64'(rf[ai]) * 64'(rf[bi]);
         acc = acc + prod;
      end
      sacc = $signed(acc);
`ifdef MAC_SATURATE_EN
      if (sgn)                     wb = (sacc > SMAX) ? 32'h7FFFFFFF : (sacc < SMIN) ? 32'h80000000 : acc[31:0];
      else                         wb = (acc > 64'hFFFFFFFF) ? 32'hFFFFFFFF : acc[31:0];
`else
      wb = acc[31:0];
      if (sacc > SMAX && sgn) wb = acc[31:0];
`endif
      for (int k = 1; k <= 2 * n + 2; k++) begin
         @(posedge clock);
         @(negedge clock);
         i = (k - 1) / 2;
         if (k <= 2 * n && (k % 2) == 1) begin
            emir = {1'b1, 5'(rd), 5'((rs1 + i) % 32), 5'((rs2 + i) % 32), 8'(cnt - i), sgn, clr};
            chk("fetch_busy", mac_busy, 1);
            chk("fetch_addr1", rf_rd_addr1, 64'((rs1 + i) % 32));
            chk("fetch_addr2", rf_rd_addr2, 64'((rs2 + i) % 32));
            chk("fetch_mir", MIR_updated, emir);
            chk("fetch_wr_en", rf_wr_en, 0);
            if (k == abort_k) begin
               reset    = 1'b0;
               load_val = '0;
               load_q   = 1'b1;
               @(posedge clock);
               @(negedge clock);
               chk("abort_busy", mac_busy, 0);
               chk("abort_wr_en", rf_wr_en, 0);
               chk("abort_done", mac_done, 0);
               reset  = 1'b1;
               load_q = 1'b0;
               m_acc  = '0;
               return;
            end
         end else if (k <= 2 * n) begin
            emir = {1'b1, 5'(rd), 5'((rs1 + i + 1) % 32), 5'((rs2 + i + 1) % 32), 8'(cnt - i - 1), sgn, clr};
            chk("mult_mir", MIR_updated, emir);
            chk("mult_done", mac_done, 0);
            chk("mult_wr_en", rf_wr_en, 0);
            if (k == 2 * n) scramble_rf();
         end else if (k == 2 * n + 1) begin
            chk("write_done", mac_done, 1);
            chk("write_en", rf_wr_en, (rd != 0));
            chk("write_addr", rf_wr_addr, 64'(rd));
            chk("write_data", rf_wr_data, wb);
            chk("write_mir_valid", MIR_updated[25], 0);
            if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
         end else begin
            chk("idle_busy", mac_busy, 0);
            chk("idle_done", mac_done, 0);
            chk("idle_wr_en", rf_wr_en, 0);
         end
      end
      m_acc = acc;
   endtask

   initial begin
      logic [25:0] ins;
      scramble_rf();
      m_acc    = '0;
      reset    = 1'b0;
      rf[1]    = 32'd7;
      rf[2]    = 32'd6;
      ins      = mk(5, 1, 2, 1, 0, 1);
      load_val = ins;
      load_q   = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge clock);
         @(negedge clock);
         load_q = 1'b0;
         chk("reset_busy", mac_busy, 0);
         chk("reset_wr_en", rf_wr_en, 0);
         chk("reset_done", mac_done, 0);
      end
      reset = 1'b1;
      follow(ins, 0);
      chk("single_result", rf[5], 32'd42);

      rf[1] = 32'd1;
      rf[2] = 32'd1;
      ins   = mk(6, 1, 2, 1, 0, 0);
      issue(ins);
      follow(ins, 0);
      chk("chain_result", rf[6], 32'd43);

      rf[10] = 32'hFFFFFFFE; rf[11] = 32'd3;        rf[12] = 32'd4;
      rf[20] = 32'd5;        rf[21] = 32'hFFFFFFFF; rf[22] = 32'd2;
      ins    = mk(7, 10, 20, 3, 1, 1);
      issue(ins);
      follow(ins, 0);
      chk("dot_result", rf[7], 32'hFFFFFFFB);

      ins = mk(0, 31, 30, 2, 0, 1);
      issue(ins);
      follow(ins, 0);

      rf[1] = 32'h7FFFFFFF;
      rf[2] = 32'h7FFFFFFF;
      ins   = mk(9, 1, 1, 2, 1, 1);
      issue(ins);
      follow(ins, 0);
`ifdef MAC_SATURATE_EN
      chk("ovf_result", rf[9], 32'h7FFFFFFF);
`else
      chk("ovf_result", rf[9], 32'h00000002);
`endif

      rf[1] = 32'h7FFFFFFF;
      rf[2] = 32'h7FFFFFFF;
      issue(ins);
      follow(ins, 3);

      for (int t = 0; t < 12; t++) begin
         ins = mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         issue(ins);
         follow(ins, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
